// File: rtl/elevator_pkg.sv
// Shared types and helpers for the elevator request path.
package elevator_pkg;

    localparam int NUM_FLOORS_DEF = 8;
    localparam int MAX_FLOORS     = 64;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        DWELL = 2'd2
    } sched_state_t;

    // Callers zero-extend narrower floor vectors to MAX_FLOORS bits.
    function automatic logic is_onehot(input logic [MAX_FLOORS-1:0] v);
        return (v != '0) && ((v & (v - 64'd1)) == '0);
    endfunction

endpackage

// File: rtl/floor_select.sv
// Combinational SCAN picker: nearest pending floor in the sweep direction,
// reversing the sweep when nothing is left ahead.
module floor_select #(
    parameter int NUM_FLOORS = 8
) (
    input  logic [NUM_FLOORS-1:0] pending,
    input  logic [NUM_FLOORS-1:0] current_floor,
    input  logic                  sweep_up,
    output logic [NUM_FLOORS-1:0] target,
    output logic                  new_dir,
    output logic                  valid,
    output logic                  serve_here
);

    logic [NUM_FLOORS-1:0] w_above;
    logic [NUM_FLOORS-1:0] w_below;
    logic [NUM_FLOORS-1:0] w_up;
    logic [NUM_FLOORS-1:0] w_dn;
    logic [NUM_FLOORS-1:0] w_up_pick;
    logic [NUM_FLOORS-1:0] w_dn_pick;

    always_comb begin
        w_above = '0;
        w_below = '0;
        for (int i = 0; i < NUM_FLOORS; i++) begin
            for (int j = 0; j < NUM_FLOORS; j++) begin
                if (current_floor[j] && (j < i)) w_above[i] = 1'b1;
                if (current_floor[j] && (j > i)) w_below[i] = 1'b1;
            end
        end
    end

    assign w_up = pending & w_above;
    assign w_dn = pending & w_below;

    // Going up we want the closest floor above (lowest bit); going down the highest bit.
    always_comb begin
        w_up_pick = '0;
        w_dn_pick = '0;
        for (int i = NUM_FLOORS - 1; i >= 0; i--) begin
            if (w_up[i]) begin
                w_up_pick    = '0;
                w_up_pick[i] = 1'b1;
            end
        end
        for (int i = 0; i < NUM_FLOORS; i++) begin
            if (w_dn[i]) begin
                w_dn_pick    = '0;
                w_dn_pick[i] = 1'b1;
            end
        end
    end

    always_comb begin
        target  = '0;
        new_dir = sweep_up;
        if (sweep_up) begin
            if (|w_up) begin
                target  = w_up_pick;
                new_dir = 1'b1;
            end else if (|w_dn) begin
                target  = w_dn_pick;
                new_dir = 1'b0;
            end
        end else begin
            if (|w_dn) begin
                target  = w_dn_pick;
                new_dir = 1'b0;
            end else if (|w_up) begin
                target  = w_up_pick;
                new_dir = 1'b1;
            end
        end
    end

    assign valid      = |target;
    assign serve_here = |(pending & current_floor);

endmodule

// File: rtl/floor_request_scheduler.sv
// SCAN request scheduler feeding elevator_controller: latches presses, issues
// one target at a time, dwells after each arrival. Optional watchdog: SCHED_WATCHDOG_EN.
module floor_request_scheduler
    import elevator_pkg::*;
#(
    parameter int NUM_FLOORS    = NUM_FLOORS_DEF,
    parameter int DWELL_CYCLES  = 4,
    parameter int ISSUE_TIMEOUT = 64
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [NUM_FLOORS-1:0] button_press,
    input  logic [NUM_FLOORS-1:0] current_floor,
    input  logic                  complete,
    output logic [NUM_FLOORS-1:0] request_floor,
    output logic [NUM_FLOORS-1:0] pending,
    output logic                  sweep_up,
    output logic                  busy,
    output logic                  floor_fault,
    output logic                  over_time
);

    localparam int DW_W = $clog2(DWELL_CYCLES + 1);

    sched_state_t          r_state;
    logic [NUM_FLOORS-1:0] r_pending;
    logic [NUM_FLOORS-1:0] r_req;
    logic                  r_sweep_up;
    logic                  r_busy;
    logic [DW_W-1:0]       r_dwell;

    logic [NUM_FLOORS-1:0] w_clear;
    logic [NUM_FLOORS-1:0] w_target;
    logic                  w_new_dir;
    logic                  w_valid;
    logic                  w_serve_here;
    logic                  w_fault;

    assign w_fault = !is_onehot(64'(current_floor));

    floor_select #(
        .NUM_FLOORS(NUM_FLOORS)
    ) u_select (
        .pending      (r_pending),
        .current_floor(current_floor),
        .sweep_up     (r_sweep_up),
        .target       (w_target),
        .new_dir      (w_new_dir),
        .valid        (w_valid),
        .serve_here   (w_serve_here)
    );

    // A clear beats a same-cycle press on that floor, so the press counts as served.
    always_comb begin
        w_clear = '0;
        if (r_state == IDLE && !w_fault && w_serve_here) begin
            w_clear = current_floor;
        end else if (r_state == ISSUE && complete) begin
            w_clear = r_req;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_pending <= '0;
        end else begin
            r_pending <= (r_pending | button_press) & ~w_clear;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state    <= IDLE;
            r_req      <= '0;
            r_sweep_up <= 1'b1;
            r_busy     <= 1'b0;
            r_dwell    <= '0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (!w_fault) begin
                        if (w_serve_here) begin
                            r_dwell <= DW_W'(DWELL_CYCLES);
                            r_busy  <= 1'b1;
                            r_state <= DWELL;
                        end else if (w_valid) begin
                            r_req      <= w_target;
                            r_sweep_up <= w_new_dir;
                            r_busy     <= 1'b1;
                            r_state    <= ISSUE;
                        end
                    end
                end
                ISSUE: begin
                    if (complete) begin
                        r_req   <= '0;
                        r_dwell <= DW_W'(DWELL_CYCLES);
                        r_state <= DWELL;
                    end
                end
                DWELL: begin
                    if (r_dwell <= DW_W'(1)) begin
                        r_dwell <= '0;
                        r_busy  <= 1'b0;
                        r_state <= IDLE;
                    end else begin
                        r_dwell <= r_dwell - 1'b1;
                    end
                end
                default: begin
                    r_req   <= '0;
                    r_busy  <= 1'b0;
                    r_state <= IDLE;
                end
            endcase
        end
    end

`ifdef SCHED_WATCHDOG_EN
    localparam int WD_W = $clog2(ISSUE_TIMEOUT + 1);

    logic [WD_W-1:0] r_wd_cnt;
    logic            r_over_time;

    // Counter is held at zero outside ISSUE so each issue starts a fresh window.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_wd_cnt    <= '0;
            r_over_time <= 1'b0;
        end else if (r_state == ISSUE) begin
            if (complete) begin
                r_wd_cnt    <= '0;
                r_over_time <= 1'b0;
            end else if (r_wd_cnt != WD_W'(ISSUE_TIMEOUT)) begin
                r_wd_cnt <= r_wd_cnt + 1'b1;
                if (r_wd_cnt == WD_W'(ISSUE_TIMEOUT - 1)) r_over_time <= 1'b1;
            end
        end else begin
            r_wd_cnt <= '0;
        end
    end

    assign over_time = r_over_time;
`else
    localparam int unused_issue_timeout = ISSUE_TIMEOUT;

    assign over_time = 1'b0;
`endif

    assign request_floor = r_req;
    assign pending       = r_pending;
    assign sweep_up      = r_sweep_up;
    assign busy          = r_busy;
    assign floor_fault   = w_fault;

endmodule

// File: tb/tb_floor_request_scheduler.sv
// Cycle-by-cycle vector table for floor_request_scheduler plus reset and watchdog sequences.
module tb_floor_request_scheduler;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic [7:0] button_press = '0;
    logic [7:0] current_floor = 8'h02;
    logic       complete = 1'b0;
    logic [7:0] request_floor;
    logic [7:0] pending;
    logic       sweep_up;
    logic       busy;
    logic       floor_fault;
    logic       over_time;

`ifdef SCHED_WATCHDOG_EN
    localparam logic WD = 1'b1;
`else
    localparam logic WD = 1'b0;
`endif

    typedef struct {
        logic       rst;
        logic [7:0] press;
        logic [7:0] cur;
        logic       cmp;
        logic [7:0] req;
        logic [7:0] pend;
        logic       sw;
        logic       bsy;
        logic       flt;
    } vec_t;

    vec_t tv[64];
    int   ntv = 0;
    int   n_total = 0;
    int   n_bad = 0;

    floor_request_scheduler #(
        .NUM_FLOORS   (8),
        .DWELL_CYCLES (4),
        .ISSUE_TIMEOUT(64)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .button_press (button_press),
        .current_floor(current_floor),
        .complete     (complete),
        .request_floor(request_floor),
        .pending      (pending),
        .sweep_up     (sweep_up),
        .busy         (busy),
        .floor_fault  (floor_fault),
        .over_time    (over_time)
    );

    always #5 clk = ~clk;

    task automatic add(input logic rst, input logic [7:0] press, input logic [7:0] cur,
                       input logic cmp, input logic [7:0] req, input logic [7:0] pend,
                       input logic sw, input logic bsy, input logic flt);
        tv[ntv] = '{rst, press, cur, cmp, req, pend, sw, bsy, flt};
        ntv++;
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic check_outputs(input string tag, input logic [7:0] req, input logic [7:0] pend,
                                 input logic sw, input logic bsy, input logic flt, input logic ovt);
        check({tag, ".req"},  32'(request_floor), 32'(req));
        check({tag, ".pend"}, 32'(pending),       32'(pend));
        check({tag, ".sw"},   32'(sweep_up),      32'(sw));
        check({tag, ".busy"}, 32'(busy),          32'(bsy));
        check({tag, ".flt"},  32'(floor_fault),   32'(flt));
        check({tag, ".ovt"},  32'(over_time),     32'(ovt));
    endtask

    initial begin
        #100000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1);
    end

    initial begin
        // rst press cur cmp | req pend sw busy flt
        add(1, 8'h00, 8'h02, 0, 8'h00, 8'h00, 1, 0, 0);
        // floor1 -> press floor4, served after two edges, then 4-cycle dwell
        add(0, 8'h10, 8'h02, 0, 8'h00, 8'h10, 1, 0, 0);
        add(0, 8'h00, 8'h02, 0, 8'h10, 8'h10, 1, 1, 0);
        add(0, 8'h00, 8'h04, 0, 8'h10, 8'h10, 1, 1, 0);
        add(0, 8'h00, 8'h10, 1, 8'h00, 8'h00, 1, 1, 0);
        add(0, 8'h00, 8'h10, 1, 8'h00, 8'h00, 1, 1, 0);
        add(0, 8'h00, 8'h10, 0, 8'h00, 8'h00, 1, 1, 0);
        add(0, 8'h00, 8'h10, 0, 8'h00, 8'h00, 1, 1, 0);
        add(0, 8'h00, 8'h10, 0, 8'h00, 8'h00, 1, 0, 0);
        // floor5 sweeping up, only floor2 pending -> reverse
        add(0, 8'h04, 8'h20, 0, 8'h00, 8'h04, 1, 0, 0);
        add(0, 8'h00, 8'h20, 0, 8'h04, 8'h04, 0, 1, 0);
        add(0, 8'h00, 8'h04, 1, 8'h00, 8'h00, 0, 1, 0);
        for (int k = 0; k < 3; k++) add(0, 8'h00, 8'h04, 0, 8'h00, 8'h00, 0, 1, 0);
        add(0, 8'h00, 8'h04, 0, 8'h00, 8'h00, 0, 0, 0);
        // reset from IDLE restores sweep_up; then floor1 up with 0,3,6 pending
        add(1, 8'h00, 8'h02, 0, 8'h00, 8'h00, 1, 0, 0);
        add(0, 8'h49, 8'h02, 0, 8'h00, 8'h49, 1, 0, 0);
        add(0, 8'h00, 8'h02, 0, 8'h08, 8'h49, 1, 1, 0);
        add(0, 8'h00, 8'h08, 1, 8'h00, 8'h41, 1, 1, 0);
        for (int k = 0; k < 3; k++) add(0, 8'h00, 8'h08, 0, 8'h00, 8'h41, 1, 1, 0);
        add(0, 8'h00, 8'h08, 0, 8'h00, 8'h41, 1, 0, 0);
        add(0, 8'h00, 8'h08, 0, 8'h40, 8'h41, 1, 1, 0);
        add(0, 8'h04, 8'h08, 0, 8'h40, 8'h45, 1, 1, 0);
        add(0, 8'h00, 8'h40, 1, 8'h00, 8'h05, 1, 1, 0);
        for (int k = 0; k < 3; k++) add(0, 8'h00, 8'h40, 0, 8'h00, 8'h05, 1, 1, 0);
        add(0, 8'h00, 8'h40, 0, 8'h00, 8'h05, 1, 0, 0);
        add(0, 8'h00, 8'h40, 0, 8'h04, 8'h05, 0, 1, 0);
        add(0, 8'h00, 8'h04, 1, 8'h00, 8'h01, 0, 1, 0);
        for (int k = 0; k < 3; k++) add(0, 8'h00, 8'h04, 0, 8'h00, 8'h01, 0, 1, 0);
        add(0, 8'h00, 8'h04, 0, 8'h00, 8'h01, 0, 0, 0);
        add(0, 8'h00, 8'h04, 0, 8'h01, 8'h01, 0, 1, 0);
        add(0, 8'h00, 8'h01, 1, 8'h00, 8'h00, 0, 1, 0);
        for (int k = 0; k < 3; k++) add(0, 8'h00, 8'h01, 0, 8'h00, 8'h00, 0, 1, 0);
        add(0, 8'h00, 8'h01, 0, 8'h00, 8'h00, 0, 0, 0);
        // press at the current floor: served in place, same-cycle re-press absorbed
        add(0, 8'h08, 8'h08, 0, 8'h00, 8'h08, 0, 0, 0);
        add(0, 8'h08, 8'h08, 0, 8'h00, 8'h00, 0, 1, 0);
        for (int k = 0; k < 3; k++) add(0, 8'h00, 8'h08, 0, 8'h00, 8'h00, 0, 1, 0);
        add(0, 8'h00, 8'h08, 0, 8'h00, 8'h00, 0, 0, 0);
        // invalid position (zero, then two-hot) blocks issue; restoring issues
        add(0, 8'h20, 8'h00, 0, 8'h00, 8'h20, 0, 0, 1);
        add(0, 8'h00, 8'h00, 0, 8'h00, 8'h20, 0, 0, 1);
        add(0, 8'h01, 8'h18, 0, 8'h00, 8'h21, 0, 0, 1);
        add(0, 8'h00, 8'h08, 0, 8'h01, 8'h21, 0, 1, 0);

        for (int i = 0; i < ntv; i++) begin
            @(negedge clk);
            reset         = tv[i].rst;
            button_press  = tv[i].press;
            current_floor = tv[i].cur;
            complete      = tv[i].cmp;
            @(posedge clk);
            #1;
            check_outputs($sformatf("v%0d", i), tv[i].req, tv[i].pend, tv[i].sw,
                          tv[i].bsy, tv[i].flt, 1'b0);
        end

        // Asynchronous reset in the middle of an ISSUE
        @(negedge clk);
        button_press = '0;
        reset = 1'b1;
        #1;
        check_outputs("arst", 8'h00, 8'h00, 1'b1, 1'b0, 1'b0, 1'b0);
        @(posedge clk);
        #1;
        check_outputs("arst_hold", 8'h00, 8'h00, 1'b1, 1'b0, 1'b0, 1'b0);
        @(negedge clk);
        reset = 1'b0;
        @(posedge clk);
        #1;
        check_outputs("arst_rel", 8'h00, 8'h00, 1'b1, 1'b0, 1'b0, 1'b0);

        // Withhold complete for a long ISSUE
        @(negedge clk);
        current_floor = 8'h02;
        button_press  = 8'h10;
        @(posedge clk);
        @(negedge clk);
        button_press = '0;
        @(posedge clk);
        #1;
        check("wd.issue", 32'(request_floor), 32'h10);
        for (int k = 1; k <= 70; k++) begin
            @(negedge clk);
            @(posedge clk);
            #1;
            if (k == 63) check("wd.ovt63", 32'(over_time), 32'h0);
            if (k == 64) check("wd.ovt64", 32'(over_time), 32'(WD));
            if (k == 70) begin
                check("wd.ovt70", 32'(over_time), 32'(WD));
                check("wd.req70", 32'(request_floor), 32'h10);
            end
        end
        @(negedge clk);
        current_floor = 8'h10;
        complete = 1'b1;
        @(posedge clk);
        #1;
        check_outputs("wd.done", 8'h00, 8'h00, 1'b1, 1'b1, 1'b0, 1'b0);
        @(negedge clk);
        complete = 1'b0;

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
